// File: rtl/axi_tlb_pkg.sv
// Shared types and constants for the TLB read-side translation stage.
// Channel structs are the default payload types; the top accepts overrides.
package axi_tlb_pkg;

   localparam int unsigned AddrW     = 48;
   localparam int unsigned IdW       = 4;
   localparam int unsigned DataW     = 64;
   localparam int unsigned PageOffsW = 12;

   localparam logic [1:0] RespDecErr = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      RES   = 3'd2,
      FWD   = 3'd3,
      DRAIN = 3'd4,
      ERR   = 3'd5
   } rd_xlate_state_e;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic             lock;
      logic [3:0]       cache;
      logic [2:0]       prot;
      logic [3:0]       qos;
      logic [3:0]       region;
      logic [0:0]       user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic [1:0]       resp;
      logic             last;
      logic [0:0]       user;
   } r_chan_t;

   typedef struct packed {
      logic             hit;
      logic [AddrW-1:0] addr;
   } res_t;

endpackage

// File: rtl/axi_tlb_rd_err_gen.sv
// Emits a DECERR R burst of len+1 beats for a translation miss.
// A start pulse loads id/len; done pulses on the handshake of the last beat.
module axi_tlb_rd_err_gen
   import axi_tlb_pkg::*;
#(
   parameter type         r_chan_t = axi_tlb_pkg::r_chan_t,
   parameter int unsigned IdWidth  = axi_tlb_pkg::IdW
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [IdWidth-1:0] id_i,
   input  logic [7:0]         len_i,
   output r_chan_t            r_o,
   output logic               r_valid_o,
   input  logic               r_ready_i,
   output logic               done_o
);

   logic               active_q, active_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         len_q, len_d;
   logic [IdWidth-1:0] id_q, id_d;
   logic               last_s;

   assign last_s    = (cnt_q == len_q);
   assign r_valid_o = active_q;

   // Burst state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         active_q <= 1'b0;
         cnt_q    <= 8'd0;
         len_q    <= 8'd0;
         id_q     <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         id_q     <= id_d;
      end
   end

   // Beat sequencing: count stops at len, so len=255 never wraps before last.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      id_d     = id_q;
      done_o   = 1'b0;
      if (start_i) begin
         active_d = 1'b1;
         cnt_d    = 8'd0;
         len_d    = len_i;
         id_d     = id_i;
      end else if (active_q && r_ready_i) begin
         if (last_s) begin
            active_d = 1'b0;
            done_o   = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         active_d = active_q;
      end
   end

   // Error beat payload.
   always_comb begin
      r_o      = '0;
      r_o.id   = id_q;
      r_o.resp = RespDecErr;
      r_o.last = last_s;
   end

endmodule

// File: rtl/axi_tlb_rd_xlate.sv
// Read-side address translation: looks up each AR in the L1 table, forwards hits
// with the translated address and answers misses locally with DECERR beats.
module axi_tlb_rd_xlate
   import axi_tlb_pkg::*;
#(
   parameter int unsigned InpAddrWidth = 48,
   parameter int unsigned OupAddrWidth = 48,
   parameter int unsigned MaxRdTxns    = 8,
   parameter type         ar_chan_t    = axi_tlb_pkg::ar_chan_t,
   parameter type         r_chan_t     = axi_tlb_pkg::r_chan_t,
   parameter type         res_t        = axi_tlb_pkg::res_t
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  ar_chan_t                slv_ar_i,
   input  logic                    slv_ar_valid_i,
   output logic                    slv_ar_ready_o,
   output r_chan_t                 slv_r_o,
   output logic                    slv_r_valid_o,
   input  logic                    slv_r_ready_i,
   output ar_chan_t                mst_ar_o,
   output logic                    mst_ar_valid_o,
   input  logic                    mst_ar_ready_i,
   input  r_chan_t                 mst_r_i,
   input  logic                    mst_r_valid_i,
   output logic                    mst_r_ready_o,
   output logic [InpAddrWidth-1:0] l1_req_addr_o,
   output logic                    l1_req_valid_o,
   input  logic                    l1_req_ready_i,
   input  res_t                    l1_res_i,
   input  logic                    l1_res_valid_i,
   output logic                    l1_res_ready_o
);

   localparam int unsigned     CntW   = $clog2(MaxRdTxns + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRdTxns);

   rd_xlate_state_e         state_q, state_d;
   ar_chan_t                ar_q, ar_d;
   logic [OupAddrWidth-1:0] xaddr_q, xaddr_d;
   logic [CntW-1:0]         out_cnt_q, out_cnt_d;

   logic    mst_ar_hs_s;
   logic    mst_r_last_hs_s;
   logic    err_start_s;
   logic    err_ready_s;
   logic    err_valid_s;
   logic    err_done_s;
   r_chan_t err_r_s;

   assign l1_req_addr_o   = ar_q.addr;
   assign mst_ar_hs_s     = mst_ar_valid_o && mst_ar_ready_i;
   assign mst_r_last_hs_s = mst_r_valid_i && mst_r_ready_o && mst_r_i.last;

   // State, held AR, translated address and in-flight read count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ar_q      <= '0;
         xaddr_q   <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ar_q      <= ar_d;
         xaddr_q   <= xaddr_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Next-state logic; a miss waits for all downstream reads so R order is kept.
   always_comb begin
      state_d     = state_q;
      ar_d        = ar_q;
      xaddr_d     = xaddr_q;
      err_start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (slv_ar_valid_i) begin
               ar_d    = slv_ar_i;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (l1_req_ready_i) state_d = RES;
            else                state_d = REQ;
         end
         RES: begin
            if (l1_res_valid_i) begin
               xaddr_d = l1_res_i.addr;
               state_d = l1_res_i.hit ? FWD : DRAIN;
            end else begin
               state_d = RES;
            end
         end
         FWD: begin
            if (mst_ar_hs_s) state_d = IDLE;
            else             state_d = FWD;
         end
         DRAIN: begin
            if (out_cnt_q == '0) begin
               err_start_s = 1'b1;
               state_d     = ERR;
            end else begin
               state_d = DRAIN;
            end
         end
         ERR: begin
            if (err_done_s) state_d = IDLE;
            else            state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Channel outputs and R mux.
   always_comb begin
      slv_ar_ready_o = 1'b0;
      l1_req_valid_o = 1'b0;
      l1_res_ready_o = 1'b0;
      mst_ar_valid_o = 1'b0;
      mst_ar_o       = ar_q;
      mst_ar_o.addr  = xaddr_q;
      slv_r_o        = mst_r_i;
      slv_r_valid_o  = mst_r_valid_i;
      mst_r_ready_o  = slv_r_ready_i;
      err_ready_s    = 1'b0;
      case (state_q)
         IDLE:  slv_ar_ready_o = 1'b1;
         REQ:   l1_req_valid_o = 1'b1;
         RES:   l1_res_ready_o = 1'b1;
         FWD:   mst_ar_valid_o = (out_cnt_q < MaxCnt);
         DRAIN: mst_ar_valid_o = 1'b0;
         ERR: begin
            slv_r_o       = err_r_s;
            slv_r_valid_o = err_valid_s;
            mst_r_ready_o = 1'b0;
            err_ready_s   = slv_r_ready_i;
         end
         default: slv_ar_ready_o = 1'b0;
      endcase
   end

   // Outstanding reads: +1 per forwarded AR, -1 per last R beat.
   always_comb begin
      out_cnt_d = out_cnt_q;
      if (mst_ar_hs_s && !mst_r_last_hs_s) begin
         out_cnt_d = out_cnt_q + CntW'(1);
      end else if (!mst_ar_hs_s && mst_r_last_hs_s && (out_cnt_q != '0)) begin
         out_cnt_d = out_cnt_q - CntW'(1);
      end else begin
         out_cnt_d = out_cnt_q;
      end
   end

   axi_tlb_rd_err_gen #(
      .r_chan_t (r_chan_t),
      .IdWidth  ($bits(ar_q.id))
   ) u_err_gen (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (err_start_s),
      .id_i      (ar_q.id),
      .len_i     (ar_q.len),
      .r_o       (err_r_s),
      .r_valid_o (err_valid_s),
      .r_ready_i (err_ready_s),
      .done_o    (err_done_s)
   );

endmodule

// File: tb/tb_axi_tlb_rd_xlate.sv
// Self-checking bench for axi_tlb_rd_xlate (MaxRdTxns=2): directed vector table
// plus hand-written ordering, full, reset and random-backpressure sequences.
module tb_axi_tlb_rd_xlate;
   import axi_tlb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   ar_chan_t    slv_ar_i;
   logic        slv_ar_valid_i;
   logic        slv_ar_ready_o;
   r_chan_t     slv_r_o;
   logic        slv_r_valid_o;
   logic        slv_r_ready_i;
   ar_chan_t    mst_ar_o;
   logic        mst_ar_valid_o;
   logic        mst_ar_ready_i;
   r_chan_t     mst_r_i;
   logic        mst_r_valid_i;
   logic        mst_r_ready_o;
   logic [47:0] l1_req_addr_o;
   logic        l1_req_valid_o;
   logic        l1_req_ready_i;
   res_t        l1_res_i;
   logic        l1_res_valid_i;
   logic        l1_res_ready_o;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk_i = ~clk_i;

   axi_tlb_rd_xlate #(.MaxRdTxns(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_ar_i(slv_ar_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
      .slv_r_o(slv_r_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
      .mst_ar_o(mst_ar_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
      .mst_r_i(mst_r_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
      .l1_req_addr_o(l1_req_addr_o), .l1_req_valid_o(l1_req_valid_o), .l1_req_ready_i(l1_req_ready_i),
      .l1_res_i(l1_res_i), .l1_res_valid_i(l1_res_valid_i), .l1_res_ready_o(l1_res_ready_o)
   );

   typedef struct {
      ar_chan_t    ar;
      res_t        res;
      logic        exp_fwd;
      logic [47:0] exp_addr;
   } vec_t;

   vec_t vecs[4];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic ar_chan_t mk_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len);
      ar_chan_t a;
      a        = '0;
      a.id     = id;
      a.addr   = addr;
      a.len    = len;
      a.size   = 3'd3;
      a.burst  = 2'd1;
      a.cache  = 4'h3;
      a.prot   = 3'd2;
      a.qos    = 4'h1;
      a.region = 4'h2;
      a.user   = 1'b1;
      return a;
   endfunction

   function automatic r_chan_t mk_r(input logic [3:0] id, input logic [63:0] data,
                                    input logic [1:0] resp, input logic last);
      r_chan_t r;
      r      = '0;
      r.id   = id;
      r.data = data;
      r.resp = resp;
      r.last = last;
      return r;
   endfunction

   function automatic res_t mk_res(input logic hit, input logic [47:0] addr);
      res_t r;
      r.hit  = hit;
      r.addr = addr;
      return r;
   endfunction

   // Presents one AR aligned to posedge+1, returns at posedge+1 after its handshake.
   task automatic do_ar(input ar_chan_t a);
      int n;
      n = 0;
      @(posedge clk_i); #1;
      slv_ar_i       = a;
      slv_ar_valid_i = 1'b1;
      @(negedge clk_i);
      while (!slv_ar_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk1("ar_accept", slv_ar_ready_o, 1'b1);
      @(posedge clk_i); #1;
      slv_ar_valid_i = 1'b0;
   endtask

   // One downstream R beat; checks it appears on the upstream side unchanged.
   task automatic send_r(input r_chan_t r);
      mst_r_i       = r;
      mst_r_valid_i = 1'b1;
      @(negedge clk_i);
      chk1("r_pass_valid", slv_r_valid_o, 1'b1);
      chkv("r_pass_data", 128'(slv_r_o), 128'(r));
      chk1("r_pass_ready", mst_r_ready_o, 1'b1);
      @(posedge clk_i); #1;
      mst_r_valid_i = 1'b0;
   endtask

   task automatic wait_mst_ar(input string name);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!mst_ar_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk1(name, mst_ar_valid_o, 1'b1);
   endtask

   task automatic wait_r_valid(input string name);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!slv_r_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      chk1(name, slv_r_valid_o, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ar_chan_t   exp_ar;
      logic [7:0] q_len[$];
      logic [3:0] q_id[$];
      logic [7:0] cur_len;
      logic [3:0] cur_id;
      int         acc, model, beat, cyc;
      logic       ar_hs, mar_hs, mr_hs, done;
      logic       p_mar, p_l1, p_slr;
      ar_chan_t   p_mar_pl;
      logic [47:0] p_l1_pl;
      r_chan_t    p_slr_pl;

      vecs[0] = '{ar: mk_ar(4'd1, 48'h0000_1000_0234, 8'd3), res: mk_res(1'b1, 48'h0008_0000_0234),
                  exp_fwd: 1'b1, exp_addr: 48'h0008_0000_0234};
      vecs[1] = '{ar: mk_ar(4'd5, 48'h0000_2000_0000, 8'd2), res: mk_res(1'b0, 48'h0),
                  exp_fwd: 1'b0, exp_addr: 48'h0};
      vecs[2] = '{ar: mk_ar(4'hF, 48'hFFFF_FFFF_FFFF, 8'd0), res: mk_res(1'b1, 48'h1234_5678_9ABC),
                  exp_fwd: 1'b1, exp_addr: 48'h1234_5678_9ABC};
      vecs[3] = '{ar: mk_ar(4'd2, 48'h0, 8'd0), res: mk_res(1'b0, 48'hDEAD),
                  exp_fwd: 1'b0, exp_addr: 48'h0};

      rst_ni = 1'b0; slv_ar_i = '0; slv_ar_valid_i = 1'b0; slv_r_ready_i = 1'b1;
      mst_ar_ready_i = 1'b0; mst_r_i = '0; mst_r_valid_i = 1'b0;
      l1_req_ready_i = 1'b0; l1_res_i = '0; l1_res_valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk1("rst_slv_ar_ready", slv_ar_ready_o, 1'b1);
      chk1("rst_l1_req_valid", l1_req_valid_o, 1'b0);
      chk1("rst_l1_res_ready", l1_res_ready_o, 1'b0);
      chk1("rst_mst_ar_valid", mst_ar_valid_o, 1'b0);
      chk1("rst_slv_r_valid", slv_r_valid_o, 1'b0);
      chk1("rst_mst_r_ready", mst_r_ready_o, 1'b1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1; l1_req_ready_i = 1'b1; l1_res_valid_i = 1'b1;

      // Table: hit/miss vectors with fastest L1 response.
      for (int v = 0; v < 4; v++) begin
         l1_res_i = vecs[v].res;
         do_ar(vecs[v].ar);
         @(negedge clk_i);
         chk1("l1_req_valid", l1_req_valid_o, 1'b1);
         chkv("l1_req_addr", 128'(l1_req_addr_o), 128'(vecs[v].ar.addr));
         @(negedge clk_i);
         chk1("l1_res_ready", l1_res_ready_o, 1'b1);
         chk1("mst_ar_early", mst_ar_valid_o, 1'b0);
         @(negedge clk_i);
         chk1("mst_ar_valid_lat3", mst_ar_valid_o, vecs[v].exp_fwd);
         if (vecs[v].exp_fwd) begin
            exp_ar      = vecs[v].ar;
            exp_ar.addr = vecs[v].exp_addr;
            chkv("mst_ar_payload", 128'(mst_ar_o), 128'(exp_ar));
            @(negedge clk_i);
            chk1("mst_ar_hold_valid", mst_ar_valid_o, 1'b1);
            chkv("mst_ar_hold_payload", 128'(mst_ar_o), 128'(exp_ar));
            mst_ar_ready_i = 1'b1;
            @(posedge clk_i); #1;
            mst_ar_ready_i = 1'b0;
            @(negedge clk_i);
            chk1("mst_ar_dropped", mst_ar_valid_o, 1'b0);
            chk1("idle_after_fwd", slv_ar_ready_o, 1'b1);
            @(posedge clk_i); #1;
            for (int b = 0; b <= int'(vecs[v].ar.len); b++)
               send_r(mk_r(vecs[v].ar.id, 64'hDA7A_0000_0000_0000 + 64'(v * 256 + b),
                           2'(b), b == int'(vecs[v].ar.len)));
         end else begin
            for (int b = 0; b <= int'(vecs[v].ar.len); b++) begin
               @(negedge clk_i);
               chk1("err_valid", slv_r_valid_o, 1'b1);
               chkv("err_beat", 128'(slv_r_o),
                    128'(mk_r(vecs[v].ar.id, 64'h0, 2'b11, b == int'(vecs[v].ar.len))));
               chk1("err_mst_r_ready", mst_r_ready_o, 1'b0);
            end
            @(negedge clk_i);
            chk1("err_end_idle", slv_ar_ready_o, 1'b1);
            chk1("err_end_valid", slv_r_valid_o, 1'b0);
         end
      end

      // Ordering: miss waits behind an in-flight len=7 hit.
      l1_res_i = mk_res(1'b1, 48'h0004_0000_0000);
      do_ar(mk_ar(4'd3, 48'h0000_3000_0000, 8'd7));
      mst_ar_ready_i = 1'b1;
      wait_mst_ar("ord_fwd");
      @(posedge clk_i); #1;
      mst_ar_ready_i = 1'b0;
      l1_res_i = mk_res(1'b0, 48'h0);
      do_ar(mk_ar(4'd4, 48'h0000_4000_0000, 8'd1));
      repeat (4) begin
         @(negedge clk_i);
         chk1("ord_no_err_yet", slv_r_valid_o, 1'b0);
      end
      @(posedge clk_i); #1;
      for (int b = 0; b < 8; b++)
         send_r(mk_r(4'd3, 64'h0BAD_0000_0000_0000 + 64'(b), 2'b00, b == 7));
      wait_r_valid("ord_err_start");
      chkv("ord_err_beat0", 128'(slv_r_o), 128'(mk_r(4'd4, 64'h0, 2'b11, 1'b0)));
      @(negedge clk_i);
      chkv("ord_err_beat1", 128'(slv_r_o), 128'(mk_r(4'd4, 64'h0, 2'b11, 1'b1)));

      // Full: two hits outstanding block the third until one read completes.
      mst_ar_ready_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         l1_res_i = mk_res(1'b1, 48'h0005_0000_0000 + 48'(k));
         do_ar(mk_ar(4'(8 + k), 48'h0000_5000_0000 + 48'(k), 8'd0));
         wait_mst_ar("full_fill");
         @(posedge clk_i); #1;
      end
      l1_res_i = mk_res(1'b1, 48'h0005_0000_0AAA);
      do_ar(mk_ar(4'd10, 48'h0000_5000_0AAA, 8'd0));
      repeat (5) begin
         @(negedge clk_i);
         chk1("full_blocked", mst_ar_valid_o, 1'b0);
      end
      @(posedge clk_i); #1;
      send_r(mk_r(4'd8, 64'h1111, 2'b00, 1'b1));
      @(negedge clk_i);
      chk1("full_released", mst_ar_valid_o, 1'b1);
      chkv("full_released_addr", 128'(mst_ar_o.addr), 128'(48'h0005_0000_0AAA));
      @(posedge clk_i); #1;
      mst_ar_ready_i = 1'b0;
      send_r(mk_r(4'd9, 64'h2222, 2'b00, 1'b1));
      send_r(mk_r(4'd10, 64'h3333, 2'b00, 1'b1));

      // Reset during a len=4 error burst, after beat 0 has gone.
      l1_res_i = mk_res(1'b0, 48'h0);
      do_ar(mk_ar(4'd6, 48'h0000_6000_0000, 8'd4));
      wait_r_valid("rst_err_start");
      chkv("rst_err_beat0", 128'(slv_r_o), 128'(mk_r(4'd6, 64'h0, 2'b11, 1'b0)));
      @(negedge clk_i);
      chkv("rst_err_beat1", 128'(slv_r_o), 128'(mk_r(4'd6, 64'h0, 2'b11, 1'b0)));
      slv_r_ready_i = 1'b0;
      rst_ni        = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk1("rst_err_r_valid", slv_r_valid_o, 1'b0);
      chk1("rst_err_ar_ready", slv_ar_ready_o, 1'b1);
      chk1("rst_err_l1_valid", l1_req_valid_o, 1'b0);
      slv_r_ready_i = 1'b1;

      // Reset clears the in-flight count: fill to full, reset, two hits must issue.
      mst_ar_ready_i = 1'b1;
      l1_res_i = mk_res(1'b1, 48'h0007_0000_0000);
      for (int k = 0; k < 2; k++) begin
         do_ar(mk_ar(4'(11 + k), 48'h0000_7000_0000, 8'd0));
         wait_mst_ar("cnt_fill");
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int k = 0; k < 2; k++) begin
         do_ar(mk_ar(4'(13 + k), 48'h0000_7000_0000, 8'd0));
         repeat (2) @(negedge clk_i);
         @(negedge clk_i);
         chk1("rst_cnt_cleared", mst_ar_valid_o, 1'b1);
         @(posedge clk_i); #1;
      end
      mst_ar_ready_i = 1'b0;
      send_r(mk_r(4'd13, 64'h4444, 2'b00, 1'b1));
      send_r(mk_r(4'd14, 64'h5555, 2'b00, 1'b1));

      // Random backpressure on every handshake; payloads must hold while stalled.
      acc = 0; model = 0; beat = 0; cyc = 0;
      p_mar = 1'b0; p_l1 = 1'b0; p_slr = 1'b0;
      p_mar_pl = '0; p_l1_pl = '0; p_slr_pl = '0;
      cur_len = 8'd0; cur_id = 4'd0;
      done = 1'b0;
      @(posedge clk_i); #1;
      while (cyc < 4000 && !done) begin
         if (!slv_ar_valid_i && acc < 9) begin
            slv_ar_i       = mk_ar(4'(acc), 48'h0000_9000_0000 + 48'(acc), 8'(acc % 3));
            slv_ar_valid_i = 1'b1;
         end
         if (!mst_r_valid_i && q_len.size() > 0) begin
            mst_r_i       = mk_r(q_id[0], 64'($urandom), 2'b00, 8'(beat) == q_len[0]);
            mst_r_valid_i = 1'b1;
         end
         l1_req_ready_i = 1'($urandom_range(0, 1));
         l1_res_valid_i = 1'($urandom_range(0, 1));
         mst_ar_ready_i = 1'($urandom_range(0, 1));
         slv_r_ready_i  = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         if (p_mar) begin
            chk1("bp_mst_ar_valid", mst_ar_valid_o, 1'b1);
            chkv("bp_mst_ar_payload", 128'(mst_ar_o), 128'(p_mar_pl));
         end
         if (p_l1) begin
            chk1("bp_l1_valid", l1_req_valid_o, 1'b1);
            chkv("bp_l1_addr", 128'(l1_req_addr_o), 128'(p_l1_pl));
         end
         if (p_slr) begin
            chk1("bp_slv_r_valid", slv_r_valid_o, 1'b1);
            chkv("bp_slv_r_payload", 128'(slv_r_o), 128'(p_slr_pl));
         end
         if (model >= 2) chk1("bp_full_block", mst_ar_valid_o, 1'b0);
         p_mar    = mst_ar_valid_o && !mst_ar_ready_i;
         p_mar_pl = mst_ar_o;
         p_l1     = l1_req_valid_o && !l1_req_ready_i;
         p_l1_pl  = l1_req_addr_o;
         p_slr    = slv_r_valid_o && !slv_r_ready_i;
         p_slr_pl = slv_r_o;
         ar_hs    = slv_ar_valid_i && slv_ar_ready_o;
         mar_hs   = mst_ar_valid_o && mst_ar_ready_i;
         mr_hs    = mst_r_valid_i && mst_r_ready_o;
         @(posedge clk_i); #1;
         if (ar_hs) begin
            slv_ar_valid_i = 1'b0;
            cur_len        = slv_ar_i.len;
            cur_id         = slv_ar_i.id;
            l1_res_i       = mk_res((acc % 3) != 2, 48'h000A_0000_0000 + 48'(acc));
            acc++;
         end
         if (mar_hs) begin
            q_len.push_back(cur_len);
            q_id.push_back(cur_id);
            model++;
         end
         if (mr_hs) begin
            if (mst_r_i.last) begin
               void'(q_len.pop_front());
               void'(q_id.pop_front());
               beat = 0;
               model--;
            end else begin
               beat++;
            end
            mst_r_valid_i = 1'b0;
         end
         done = (acc == 9) && (model == 0) && (q_len.size() == 0) && slv_ar_ready_o && !mst_r_valid_i;
         cyc++;
      end
      chk1("bp_completed", done, 1'b1);
      chkv("bp_model_zero", 128'(model), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
